// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic {
    RUN       = 1'b0,
    MULT_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam int STALL_W = 32;

  // A producer only matters when its destination is a real register; $0 is hardwired.
  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// ALU operand forwarding comparators; EX/MEM has priority over MEM/WB.
module fwd_unit
  import hazard_pkg::*;
(
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic [4:0] mem_rd,
  input  logic       mem_regwrite,
  input  logic [4:0] wb_rd,
  input  logic       wb_regwrite,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  function automatic logic [1:0] select(input logic [4:0] src);
    if (mem_regwrite && reg_match(mem_rd, src)) return FWD_EXMEM;
    if (wb_regwrite && reg_match(wb_rd, src))   return FWD_MEMWB;
    return FWD_RF;
  endfunction

  assign fwd_a = select(ex_rs);
  assign fwd_b = select(ex_rt);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing controller: stalls, flushes, multi-cycle EX hold, forwarding.
// Define HAZARD_FORWARD_EN to enable operand forwarding (otherwise RAW hazards stall).
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         id_rs,
  input  logic [4:0]         id_rt,
  input  logic               id_uses_rt,
  input  logic [4:0]         ex_rs,
  input  logic [4:0]         ex_rt,
  input  logic [4:0]         ex_rd,
  input  logic               ex_regwrite,
  input  logic               ex_memread,
  input  logic [4:0]         mem_rd,
  input  logic               mem_regwrite,
  input  logic [4:0]         wb_rd,
  input  logic               wb_regwrite,
  input  logic               ex_branch_taken,
  input  logic               ex_mult_start,
  output logic               pc_en,
  output logic               ifid_en,
  output logic               idex_en,
  output logic               ifid_flush,
  output logic               idex_flush,
  output logic               exmem_flush,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b,
  output logic               busy,
  output logic [STALL_W-1:0] stall_cycles
);

  localparam logic [3:0] MCNT_INIT = 4'(MULT_CYCLES - 2);

  state_t     state, state_nxt;
  logic [3:0] mcnt, mcnt_nxt;
  logic       id_dep_ex, id_dep_mem, load_use, raw_stall;

  assign id_dep_ex  = reg_match(ex_rd, id_rs)  || (id_uses_rt && reg_match(ex_rd, id_rt));
  assign id_dep_mem = reg_match(mem_rd, id_rs) || (id_uses_rt && reg_match(mem_rd, id_rt));
  assign load_use   = ex_memread && ex_regwrite && id_dep_ex;

`ifdef HAZARD_FORWARD_EN
  logic [1:0] fwd_a_raw, fwd_b_raw;
  logic       unused_fwd;

  fwd_unit u_fwd (
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .fwd_a        (fwd_a_raw),
    .fwd_b        (fwd_b_raw)
  );

  assign raw_stall  = load_use;
  assign fwd_a      = rst ? FWD_RF : fwd_a_raw;
  assign fwd_b      = rst ? FWD_RF : fwd_b_raw;
  assign unused_fwd = id_dep_mem;
`else
  logic unused_fwd;

  // Without forwarding, any in-flight producer of an ID source must drain first.
  assign raw_stall  = load_use || (ex_regwrite && id_dep_ex) || (mem_regwrite && id_dep_mem);
  assign fwd_a      = FWD_RF;
  assign fwd_b      = FWD_RF;
  assign unused_fwd = ^{ex_rs, ex_rt, wb_rd, wb_regwrite};
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      mcnt         <= 4'd0;
      stall_cycles <= '0;
    end else begin
      state <= state_nxt;
      mcnt  <= mcnt_nxt;
      if (!pc_en && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    mcnt_nxt  = mcnt;
    unique case (state)
      RUN: begin
        if (!ex_branch_taken && ex_mult_start) begin
          state_nxt = MULT_WAIT;
          mcnt_nxt  = MCNT_INIT;
        end
      end
      MULT_WAIT: begin
        if (mcnt == 4'd0) state_nxt = RUN;
        else              mcnt_nxt  = mcnt - 4'd1;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    busy        = 1'b0;
    if (rst) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (state == MULT_WAIT) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_flush = 1'b1;
      busy        = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end else if (ex_mult_start) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_flush = 1'b1;
    end else if (raw_stall) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_flush  = 1'b1;
    end
  end

endmodule
